// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state enum, architectural address width and address type
package regfile_pkg;
  typedef enum logic {CLEAR, RUN} regfile_state_e;
  localparam int REG_ADDR_W = 5;
  typedef logic [REG_ADDR_W-1:0] regfile_addr_t;
endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: post-reset clear FSM walking indices 1..NREGS-1, then ready
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int NREGS = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_enable,
  output logic          clear_we,
  output logic [AW-1:0] clear_addr,
  output logic          ready
);
  regfile_state_e state, state_nx;
  logic [AW-1:0] idx, idx_nx;
  // state and clear index, advanced only on enabled edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      idx   <= AW'(1);
    end else if (clk_enable) begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end
  // leave CLEAR on the step that zeroes the last register; RUN is terminal
  always_comb begin
    state_nx = (state == CLEAR && idx == AW'(NREGS - 1)) ? RUN : state;
    idx_nx   = (state == CLEAR) ? idx + AW'(1) : idx;
  end
  assign clear_we   = state == CLEAR;
  assign clear_addr = idx;
  assign ready      = state == RUN;
endmodule

// File: rtl/regfile_bank.sv
// regfile_bank: 1W/NREAD-R registered register file, x0 = 0, hardware clear; REGFILE_BYPASS_EN selects write-first reads
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  localparam int AW     = $clog2(NREGS),
  localparam int ADDR_W = REG_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_enable,
  input  logic                    write_enable,
  input  logic [ADDR_W-1:0]       rd,
  input  logic [XLEN-1:0]         data_in,
  input  logic [NREAD*ADDR_W-1:0] rs,
  output logic [NREAD*XLEN-1:0]   data_out,
  output logic                    ready
);
  logic [XLEN-1:0] mem [NREGS];
  logic [XLEN-1:0] rd_val [NREAD];
  logic            clear_we;
  logic [AW-1:0]   clear_addr;
  logic            wr_ok;
  regfile_clear_seq #(.NREGS(NREGS)) u_clear (
    .clk        (clk),
    .rst        (rst),
    .clk_enable (clk_enable),
    .clear_we   (clear_we),
    .clear_addr (clear_addr),
    .ready      (ready)
  );
  assign wr_ok = !clear_we && write_enable && rd != '0 && 32'(rd) < 32'(NREGS);
  // storage: clear sequencer owns the port while clearing, external writes otherwise
  always_ff @(posedge clk) begin
    if (clk_enable && (clear_we || wr_ok))
      mem[clear_we ? clear_addr : rd[AW-1:0]] <= clear_we ? '0 : data_in;
  end
  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    regfile_addr_t a;
    logic          valid;
    assign a     = rs[g*ADDR_W +: ADDR_W];
    assign valid = a != '0 && 32'(a) < 32'(NREGS);
`ifdef REGFILE_BYPASS_EN
    assign rd_val[g] = !valid ? '0 : (wr_ok && rd == a) ? data_in : mem[a[AW-1:0]];
`else
    assign rd_val[g] = valid ? mem[a[AW-1:0]] : '0;
`endif
  end
  // registered read ports, forced to zero while clearing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_out <= '0;
    else if (clk_enable)
      for (int i = 0; i < NREAD; i++) data_out[i*XLEN +: XLEN] <= clear_we ? '0 : rd_val[i];
  end
endmodule

// File: tb/tb_regfile_bank.sv
// tb_regfile_bank: directed tests for regfile_bank (32- and 16-register builds)
module tb_regfile_bank;
  logic        clk = 0, rst = 1, ce = 1, we = 0;
  logic [4:0]  rd = 0;
  logic [31:0] din = 0;
  logic [9:0]  rs = 0;
  logic [63:0] dout, dout16;
  logic        rdy, rdy16;
  int vecs = 0, errs = 0;

  always #5 clk = ~clk;

  regfile_bank #(.XLEN(32), .NREGS(32), .NREAD(2)) dut (
    .clk(clk), .rst(rst), .clk_enable(ce), .write_enable(we), .rd(rd),
    .data_in(din), .rs(rs), .data_out(dout), .ready(rdy));
  regfile_bank #(.XLEN(32), .NREGS(16), .NREAD(2)) dut16 (
    .clk(clk), .rst(rst), .clk_enable(ce), .write_enable(we), .rd(rd),
    .data_in(din), .rs(rs), .data_out(dout16), .ready(rdy16));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    vecs++; if (rdy !== 1'b0) begin errs++; $display("FAIL reset_ready got %b want 0", rdy); end
    vecs++; if (rdy16 !== 1'b0) begin errs++; $display("FAIL reset_ready16 got %b want 0", rdy16); end
    vecs++; if (dout !== 64'h0) begin errs++; $display("FAIL reset_dout got %h want 0", dout); end
    tick();
    rst = 0;
  endtask

  task automatic test_clear;
    for (int e = 1; e <= 31; e++) begin
      tick();
      if (e == 14) begin vecs++; if (rdy16 !== 1'b0) begin errs++; $display("FAIL clear16_e14 got %b want 0", rdy16); end end
      if (e == 15) begin vecs++; if (rdy16 !== 1'b1) begin errs++; $display("FAIL clear16_e15 got %b want 1", rdy16); end end
      if (e == 30) begin vecs++; if (rdy !== 1'b0) begin errs++; $display("FAIL clear_e30 got %b want 0", rdy); end end
      if (e == 31) begin vecs++; if (rdy !== 1'b1) begin errs++; $display("FAIL clear_e31 got %b want 1", rdy); end end
    end
    for (int a = 0; a < 32; a++) begin
      rs = {5'(a), 5'(a)};
      tick();
      vecs++; if (dout !== 64'h0) begin errs++; $display("FAIL clear_read x%0d got %h want 0", a, dout); end
    end
  endtask

  task automatic test_clear_stall;
    int n = 0;
    rst = 1;
    #2;
    rst = 0;
    while (n < 31) begin
      ce = 1; we = 1; rd = 5'd5; din = 32'hDEAD;
      tick();
      n++;
      ce = 0;
      tick();
      if (n == 30) begin vecs++; if (rdy !== 1'b0) begin errs++; $display("FAIL stall_e30 got %b want 0", rdy); end end
    end
    vecs++; if (rdy !== 1'b1) begin errs++; $display("FAIL stall_e31 got %b want 1", rdy); end
    ce = 1; we = 0; rs = {5'd0, 5'd5};
    tick();
    vecs++; if (dout[31:0] !== 32'h0) begin errs++; $display("FAIL stall_x5 got %h want 0", dout[31:0]); end
  endtask

  task automatic test_basic;
    we = 1; rd = 5'd7; din = 32'h12345678; rs = 0;
    tick();
    we = 0; rs = {5'd7, 5'd0};
    tick();
    vecs++; if (dout !== {32'h12345678, 32'h0}) begin errs++; $display("FAIL basic_x7 got %h want %h", dout, {32'h12345678, 32'h0}); end
  endtask

  task automatic test_bypass;
    we = 1; rd = 5'd9; din = 32'h1;
    tick();
    din = 32'hAA; rs = {5'd0, 5'd9};
    tick();
    we = 0;
`ifdef REGFILE_BYPASS_EN
    vecs++; if (dout[31:0] !== 32'hAA) begin errs++; $display("FAIL bypass_same got %h want aa", dout[31:0]); end
`else
    vecs++; if (dout[31:0] !== 32'h1) begin errs++; $display("FAIL readfirst_same got %h want 1", dout[31:0]); end
`endif
    tick();
    vecs++; if (dout[31:0] !== 32'hAA) begin errs++; $display("FAIL bypass_next got %h want aa", dout[31:0]); end
  endtask

  task automatic test_x0_range;
    we = 1; rd = 5'd0; din = 32'hFFFFFFFF;
    tick();
    rd = 5'd4; din = 32'h44; rs = 0;
    tick();
    vecs++; if (dout !== 64'h0) begin errs++; $display("FAIL x0_read got %h want 0", dout); end
    vecs++; if (dout16 !== 64'h0) begin errs++; $display("FAIL x0_read16 got %h want 0", dout16); end
    rd = 5'd20; din = 32'h55;
    tick();
    we = 0; rs = {5'd4, 5'd20};
    tick();
    vecs++; if (dout16 !== {32'h44, 32'h0}) begin errs++; $display("FAIL range16 got %h want %h", dout16, {32'h44, 32'h0}); end
    vecs++; if (dout !== {32'h44, 32'h55}) begin errs++; $display("FAIL range32 got %h want %h", dout, {32'h44, 32'h55}); end
  endtask

  task automatic test_hold;
    rs = {5'd7, 5'd4};
    tick();
    ce = 0; rs = 0; we = 1; rd = 5'd4; din = 32'hBAD;
    tick();
    vecs++; if (dout !== {32'h12345678, 32'h44}) begin errs++; $display("FAIL hold_dout got %h want %h", dout, {32'h12345678, 32'h44}); end
    vecs++; if (rdy !== 1'b1) begin errs++; $display("FAIL hold_ready got %b want 1", rdy); end
    ce = 1; we = 0; rs = {5'd0, 5'd4};
    tick();
    vecs++; if (dout[31:0] !== 32'h44) begin errs++; $display("FAIL hold_nowrite got %h want 44", dout[31:0]); end
  endtask

  task automatic test_back_to_back;
    we = 1; rd = 5'd10; din = 32'hA; rs = 0;
    tick();
    rd = 5'd11; din = 32'hB; rs = {5'd0, 5'd10};
    tick();
    vecs++; if (dout[31:0] !== 32'hA) begin errs++; $display("FAIL b2b_1 got %h want a", dout[31:0]); end
    rd = 5'd12; din = 32'hC; rs = {5'd10, 5'd11};
    tick();
    vecs++; if (dout !== {32'hA, 32'hB}) begin errs++; $display("FAIL b2b_2 got %h want %h", dout, {32'hA, 32'hB}); end
    we = 0; rs = {5'd11, 5'd12};
    tick();
    vecs++; if (dout !== {32'hB, 32'hC}) begin errs++; $display("FAIL b2b_3 got %h want %h", dout, {32'hB, 32'hC}); end
  endtask

  task automatic test_mid_reset;
    we = 1; rd = 5'd3; din = 32'h77; rs = 0;
    tick();
    we = 0; rs = {5'd0, 5'd3};
    tick();
    vecs++; if (dout[31:0] !== 32'h77) begin errs++; $display("FAIL mid_load got %h want 77", dout[31:0]); end
    #2 rst = 1;
    #1;
    vecs++; if (dout !== 64'h0) begin errs++; $display("FAIL mid_dout got %h want 0", dout); end
    vecs++; if (rdy !== 1'b0) begin errs++; $display("FAIL mid_ready got %b want 0", rdy); end
    #1 rst = 0;
    for (int e = 0; e < 31; e++) tick();
    vecs++; if (rdy !== 1'b1) begin errs++; $display("FAIL mid_reclear got %b want 1", rdy); end
    rs = {5'd3, 5'd3};
    tick();
    vecs++; if (dout !== 64'h0) begin errs++; $display("FAIL mid_x3 got %h want 0", dout); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_clear_stall();
    test_basic();
    test_bypass();
    test_x0_range();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
